// File: rtl/bram_1p_arbiter.sv
// Two-requester arbiter in front of one single-port read-first BRAM.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module bram_1p_arbiter #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     a_req_i,
  input  logic                     a_we_i,
  input  logic [RAM_ADDR_BITS-1:0] a_addr_i,
  input  logic [RAM_WIDTH-1:0]     a_wdata_i,
  output logic                     a_gnt_o,
  output logic                     a_rvalid_o,
  input  logic                     b_req_i,
  input  logic                     b_we_i,
  input  logic [RAM_ADDR_BITS-1:0] b_addr_i,
  input  logic [RAM_WIDTH-1:0]     b_wdata_i,
  output logic                     b_gnt_o,
  output logic                     b_rvalid_o,
  output logic [RAM_WIDTH-1:0]     rdata_o,
  output logic                     ram_en_o,
  output logic                     ram_we_o,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
  output logic [RAM_WIDTH-1:0]     ram_wdata_o,
  input  logic [RAM_WIDTH-1:0]     ram_rdata_i
);

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  logic pick_a;
  logic tag_valid;
  logic tag_id;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign pick_a = a_req_i;
`else
  logic last_grant;

  // A wins contention only when B was the last one served
  assign pick_a = a_req_i & (~b_req_i | (last_grant == ID_B));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= ID_B;
    end else if (a_gnt_o | b_gnt_o) begin
      last_grant <= b_gnt_o ? ID_B : ID_A;
    end
  end
`endif

  assign a_gnt_o = ~rst_i & pick_a;
  assign b_gnt_o = ~rst_i & b_req_i & ~pick_a;

  always_comb begin
    ram_en_o    = a_gnt_o | b_gnt_o;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    unique case (1'b1)
      a_gnt_o: begin
        ram_we_o    = a_we_i;
        ram_addr_o  = a_addr_i;
        ram_wdata_o = a_wdata_i;
      end
      b_gnt_o: begin
        ram_we_o    = b_we_i;
        ram_addr_o  = b_addr_i;
        ram_wdata_o = b_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_valid <= 1'b0;
      tag_id    <= ID_A;
    end else begin
      tag_valid <= a_gnt_o | b_gnt_o;
      tag_id    <= b_gnt_o ? ID_B : ID_A;
    end
  end

  // gating with reset drops the return of an access issued just before reset
  assign a_rvalid_o = ~rst_i & tag_valid & (tag_id == ID_A);
  assign b_rvalid_o = ~rst_i & tag_valid & (tag_id == ID_B);
  assign rdata_o    = ram_rdata_i;

endmodule

// File: tb/tb_bram_1p_arbiter.sv
// Randomized and directed bench for bram_1p_arbiter with a
// behavioural RAM and a queue-free arbitration reference model.
module tb_bram_1p_arbiter;
  localparam int W  = 8;
  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AB-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [W-1:0]  rdata;
  logic          ram_en, ram_we;
  logic [AB-1:0] ram_addr;
  logic [W-1:0]  ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;

  bram_1p_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
    .rdata_o(rdata), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // read-first single-port RAM driven by the DUT
  logic [W-1:0] ram [0:(1<<AB)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram[ram_addr];
      if (ram_we) ram[ram_addr] <= ram_wdata;
    end
  end

  // reference model state
  bit           m_last_b;
  bit           m_pv;
  bit           m_pid;
  logic [W-1:0] m_pd;
  logic [W-1:0] m_mem [0:(1<<AB)-1];

  bit            e_ag, e_bg, e_en, e_we, e_arv, e_brv;
  logic [AB-1:0] e_addr;
  logic [W-1:0]  e_wd, e_rd;

  task automatic drive(input bit ar, input bit aw, input int aa,
                       input int ad, input bit br, input bit bw,
                       input int ba, input int bd);
    a_req = ar; a_we = aw; a_addr = aa[AB-1:0]; a_wdata = ad[W-1:0];
    b_req = br; b_we = bw; b_addr = ba[AB-1:0]; b_wdata = bd[W-1:0];
  endtask

  task automatic predict();
    e_ag = 0;
    e_bg = 0;
    if (!rst) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
      e_ag = a_req;
      e_bg = b_req & !a_req;
`else
      if (a_req && b_req) begin
        e_ag = m_last_b;
        e_bg = !m_last_b;
      end else begin
        e_ag = a_req;
        e_bg = b_req;
      end
`endif
    end
    e_en   = e_ag | e_bg;
    e_we   = e_ag ? a_we : (e_bg ? b_we : 1'b0);
    e_addr = e_ag ? a_addr : (e_bg ? b_addr : '0);
    e_wd   = e_ag ? a_wdata : (e_bg ? b_wdata : '0);
    e_arv  = !rst && m_pv && !m_pid;
    e_brv  = !rst && m_pv && m_pid;
    e_rd   = m_pd;
  endtask

  task automatic commit();
    if (rst) begin
      m_pv     = 0;
      m_last_b = 1;
    end else begin
      m_pv  = e_en;
      m_pid = e_bg;
      if (e_en) begin
        m_pd = m_mem[e_addr];
        if (e_we) m_mem[e_addr] = e_wd;
        m_last_b = e_bg;
      end
    end
  endtask

  task automatic tick();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 3, 8'h55, 1, 1, 4, 8'h66);
      @(negedge clk);
      predict();
      total++;
      if ({a_gnt, b_gnt} !== 2'b00) begin
        bad++;
        $display("FAIL reset_gnt got=%b exp=00", {a_gnt, b_gnt});
      end
      total++;
      if ({ram_en, ram_we} !== 2'b00) begin
        bad++;
        $display("FAIL reset_ram got=%b exp=00", {ram_en, ram_we});
      end
      total++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
        bad++;
        $display("FAIL reset_rvalid got=%b exp=00", {a_rvalid, b_rvalid});
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_single_a();
    drive(1, 1, 5, 8'h3C, 0, 0, 0, 0);
    @(negedge clk);
    predict();
    total++;
    if (a_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd5 ||
        ram_wdata !== 8'h3C) begin
      bad++;
      $display("FAIL single_wr got gnt=%b we=%b addr=%0d wd=%h exp 1 1 5 3c",
               a_gnt, ram_we, ram_addr, ram_wdata);
    end
    tick();
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    predict();
    total++;
    if (a_rvalid !== 1'b1 || rdata !== e_rd) begin
      bad++;
      $display("FAIL single_wr_rv got rv=%b rd=%h exp 1 %h", a_rvalid, rdata, e_rd);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    predict();
    total++;
    if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || rdata !== 8'h3C) begin
      bad++;
      $display("FAIL single_rd got arv=%b brv=%b rd=%h exp 1 0 3c",
               a_rvalid, b_rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    bit exp_a;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    predict();
    tick();
    rst = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(1, 0, 1, 0, 1, 0, 2, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      predict();
      exp_a = (i % 2) == 0;
      if (i < 10) begin
        total++;
        if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
          bad++;
          $display("FAIL rr_gnt[%0d] got=%b%b exp=%b%b", i, a_gnt, b_gnt,
                   exp_a, !exp_a);
        end
      end
      if (i > 0) begin
        total++;
        if (a_rvalid !== !exp_a || b_rvalid !== exp_a || rdata !== e_rd) begin
          bad++;
          $display("FAIL rr_ret[%0d] got=%b%b %h exp=%b%b %h", i, a_rvalid,
                   b_rvalid, rdata, !exp_a, exp_a, e_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_read_first();
    drive(1, 1, 7, 8'h11, 0, 0, 0, 0);
    @(negedge clk); predict(); tick();
    drive(0, 0, 0, 0, 1, 1, 7, 8'h22);
    @(negedge clk); predict();
    total++;
    if (b_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rf_bgnt got=%b exp=1", b_gnt);
    end
    tick();
    drive(1, 0, 7, 0, 0, 0, 0, 0);
    @(negedge clk); predict();
    total++;
    if (b_rvalid !== 1'b1 || rdata !== 8'h11) begin
      bad++;
      $display("FAIL rf_old got rv=%b rd=%h exp 1 11", b_rvalid, rdata);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); predict();
    total++;
    if (a_rvalid !== 1'b1 || rdata !== 8'h22) begin
      bad++;
      $display("FAIL rf_new got rv=%b rd=%h exp 1 22", a_rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_stall();
    drive(0, 0, 0, 0, 1, 0, 8, 0);
    @(negedge clk); predict(); tick();
    drive(1, 0, 3, 0, 1, 0, 9, 0);
    @(negedge clk); predict();
    total++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_addr !== 10'd3) begin
      bad++;
      $display("FAIL stall_lose got a=%b b=%b addr=%0d exp 1 0 3",
               a_gnt, b_gnt, ram_addr);
    end
    tick();
    drive(0, 0, 0, 0, 1, 0, 9, 0);
    @(negedge clk); predict();
    total++;
    if (b_gnt !== 1'b1 || ram_addr !== 10'd9) begin
      bad++;
      $display("FAIL stall_win got b=%b addr=%0d exp 1 9", b_gnt, ram_addr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); predict();
    total++;
    if (b_rvalid !== 1'b1 || rdata !== e_rd || rdata !== m_mem[9]) begin
      bad++;
      $display("FAIL stall_ret got rv=%b rd=%h exp 1 %h", b_rvalid, rdata, e_rd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 4, 0, 0, 0, 0, 0);
    @(negedge clk); predict(); tick();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); predict();
      total++;
      if (a_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_in[%0d] got=%b exp=0", i, a_rvalid);
      end
      tick();
    end
    rst = 0;
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    @(negedge clk); predict();
    total++;
    if (a_rvalid !== 1'b0 || a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after got rv=%b a=%b b=%b exp 0 1 0",
               a_rvalid, a_gnt, b_gnt);
    end
    tick();
  endtask

  task automatic test_both_five();
    int b_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1, 0, 1, 0, 1, 0, 2, 0);
      else drive(0, 0, 0, 0, 1, 0, 2, 0);
      @(negedge clk); predict();
      total++;
      if (a_gnt !== e_ag || b_gnt !== e_bg) begin
        bad++;
        $display("FAIL five[%0d] got=%b%b exp=%b%b", i, a_gnt, b_gnt, e_ag, e_bg);
      end
      if (i < 5 && b_gnt === 1'b1) b_cnt++;
      tick();
    end
`ifdef BRAM_ARB_FIXED_PRIO_EN
    total++;
    if (b_cnt !== 0) begin
      bad++;
      $display("FAIL five_starve got=%0d exp=0", b_cnt);
    end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); predict(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15), $urandom_range(0, 255));
      @(negedge clk); predict();
      total++;
      if (a_gnt !== e_ag || b_gnt !== e_bg) begin
        bad++;
        $display("FAIL rnd_gnt[%0d] got=%b%b exp=%b%b", i, a_gnt, b_gnt, e_ag, e_bg);
      end
      total++;
      if (ram_en !== e_en || ram_we !== e_we || ram_addr !== e_addr ||
          ram_wdata !== e_wd) begin
        bad++;
        $display("FAIL rnd_ram[%0d] got=%b%b %0d %h exp=%b%b %0d %h", i, ram_en,
                 ram_we, ram_addr, ram_wdata, e_en, e_we, e_addr, e_wd);
      end
      total++;
      if (a_rvalid !== e_arv || b_rvalid !== e_brv) begin
        bad++;
        $display("FAIL rnd_rv[%0d] got=%b%b exp=%b%b", i, a_rvalid, b_rvalid,
                 e_arv, e_brv);
      end
      if (e_arv || e_brv) begin
        total++;
        if (rdata !== e_rd) begin
          bad++;
          $display("FAIL rnd_rd[%0d] got=%h exp=%h", i, rdata, e_rd);
        end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AB); i++) begin
      ram[i]   = W'(i * 37 + 5);
      m_mem[i] = W'(i * 37 + 5);
    end
    m_last_b = 1;
    m_pv     = 0;
    m_pid    = 0;
    m_pd     = '0;
    rst      = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_single_a();
    test_contention();
    test_read_first();
    test_stall();
    test_reset_mid();
    test_both_five();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_1p_arbiter.md
Name: bram_1p_arbiter

Overview:
- Shares one single-port read-first block RAM between two requesters, A and B.
- Each cycle it grants at most one requester and drives the RAM enable/write/address/data pins from that requester.
- It tags the access and returns the 1-cycle-latency read data to the requester that issued it.
- It sits between two client engines and one single-port BRAM instance, owning the RAM port exclusively.

Parameters:
- RAM_WIDTH, 8, data width of RAM word and of both requester data buses.
- RAM_ADDR_BITS, 10, address width; depth = 2**RAM_ADDR_BITS.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_req_i  in  1  requester A wants an access this cycle.
- a_we_i  in  1  A access is a write (1) or read (0).
- a_addr_i  in  RAM_ADDR_BITS  A address.
- a_wdata_i  in  RAM_WIDTH  A write data.
- a_gnt_o  out  1  A access accepted this cycle (combinational).
- a_rvalid_o  out  1  rdata_o carries result of A's access granted last cycle.
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_gnt_o, b_rvalid_o: same as A, for requester B.
- rdata_o  out  RAM_WIDTH  read data, shared by both requesters, qualified by a_rvalid_o/b_rvalid_o.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  RAM_ADDR_BITS  RAM address.
- ram_wdata_o  out  RAM_WIDTH  RAM write data.
- ram_rdata_i  in  RAM_WIDTH  RAM registered read output (read-first, 1-cycle latency).

Behaviour:
- Handshake:
  - A request is accepted in the cycle where req_i & gnt_o = 1.
  - The requester holds we/addr/wdata stable while req_i=1 and gnt_o=0.
  - gnt_o never asserts without req_i.
  - a_gnt_o & b_gnt_o is never 1.
- Arbitration:
  - Only one req high: that requester is granted the same cycle.
  - Both high: round-robin. Grant goes to the requester not recorded in last_grant.
  - last_grant register updates only on a grant. Idle cycles leave it unchanged.
- RAM drive (combinational from the winner):
  - ram_en_o = any grant; ram_we_o = winner we.
  - ram_addr_o / ram_wdata_o = winner addr/wdata.
  - With no grant: ram_en_o=0, ram_we_o=0, addr/wdata = 0.
- Return path:
  - tag register {valid, id} captures the grant each cycle.
  - a_rvalid_o = valid & id==A; b_rvalid_o = valid & id==B.
  - Both deassert the cycle after an idle cycle.
- rdata_o = ram_rdata_i, passed through with no extra register.
  - Total read latency = 1 cycle after grant.
- Writes also produce rvalid the next cycle. rdata_o then holds the old word at that address (read-first).
- Back-to-back:
  - Full throughput, one access per cycle, no bubbles.
  - Alternating A/B under continuous contention.
- Reset values:
  - last_grant = B, so A wins the first contention.
  - tag valid=0; a_rvalid_o = b_rvalid_o = 0.
  - While rst_i=1: all gnt_o = 0, ram_en_o = 0, ram_we_o = 0.
- Reset mid-operation: an access granted in the cycle before reset asserts gets no rvalid. Its RAM write has already been issued and stands.
- Same-address collision across cycles: B reads addr X the cycle after A writes X. B gets the new data, since RAM ordering is preserved by the single port.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. A always wins contention; last_grant register absent; B may starve.
- Undefined: round-robin as above.
- Single-requester behaviour, latency and reset are identical in both builds.

Test Plan:
- Single A write: A writes addr 5 = 0x3C, then A reads 5.
  - Write: a_gnt_o=1 same cycle; next cycle a_rvalid_o=1 with old data.
  - Read: a_rvalid_o=1 one cycle after grant, rdata_o=0x3C; b_rvalid_o stays 0.
- Contention round-robin: after reset, both req continuously, reads of addr 1 (A) and 2 (B).
  - Grants A,B,A,B...
  - rvalid follows one cycle later with matching id.
  - Ten accesses in ten cycles.
- Read-first write: mem[7]=0x11; B writes 7 = 0x22.
  - b_rvalid_o next cycle with rdata_o = 0x11.
  - A then reads 7: rdata_o = 0x22.
- Hold under stall: B holds req (read addr 9) while A wins.
  - b_gnt_o=0 that cycle; B's addr stays stable.
  - b_gnt_o=1 next cycle; data returns one cycle later.
- Reset mid-stream: assert rst_i one cycle after an A read grant.
  - a_rvalid_o=0 during and after reset.
  - First post-reset contention grants A.
- With BRAM_ARB_FIXED_PRIO_EN: both req for 5 cycles.
  - A granted all 5, b_gnt_o stays 0.
  - B is granted the cycle A drops req.
